// File: rtl/spi_pkg.sv
// Shared types and default depths for the SPI interface buffer.
package spi_pkg;

    localparam int WD_DEPTH_DEF = 8;
    localparam int RI_DEPTH_DEF = 4;
    localparam int RD_DEPTH_DEF = 8;
    localparam int SLV_SEL_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } t_ctl_state;

    typedef struct packed {
        logic [31:0]          rwdata;
        logic [1:0]           wd_len;
        logic                 wd_lst;
        logic                 wd_empty;
        logic [1:0]           rd_len;
        logic                 rd_lst;
        logic                 rd_inf_empty;
        logic                 rd_rdy;
        logic                 strt;
        logic [SLV_SEL_W-1:0] slv_sel;
        logic                 rdata_en;
    } t_spi_if_ro;

    typedef struct packed {
        logic        wd_r;
        logic        rd_inf_r;
        logic        rd_ind;
        logic [31:0] rdata;
        logic        done;
        logic        wdat_timeout;
        logic        rd_inf_timeout;
        logic        rdat_timeout;
    } t_spi_if_ri;

    // Sticky status update: a set event in the clearing cycle survives the clear.
    function automatic logic [5:0] sts_update(input logic [5:0] cur,
                                              input logic [5:0] set,
                                              input logic       clr);
        return clr ? set : (cur | set);
    endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock show-ahead FIFO; the head entry is visible whenever the FIFO is non-empty.
module spi_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
    assign push_ok = push & (~full | pop_ok);
    assign ovf     = push & ~push_ok;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spi_if_buf.sv
// Host-side buffering for an SPI controller: write-data, read-info and read-data FIFOs
// plus a start/done handshake FSM and sticky status.
module spi_if_buf
    import spi_pkg::*;
#(
    parameter int WD_DEPTH = WD_DEPTH_DEF,
    parameter int RI_DEPTH = RI_DEPTH_DEF,
    parameter int RD_DEPTH = RD_DEPTH_DEF,
    parameter int SLV_NUM  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wd_push,
    input  logic [31:0]                wd_data,
    input  logic [1:0]                 wd_len,
    input  logic                       wd_lst,
    input  logic                       ri_push,
    input  logic [1:0]                 ri_len,
    input  logic                       ri_lst,
    input  logic                       rd_pop,
    output logic [31:0]                rd_data,
    output logic                       rd_vld,
    input  logic                       go,
    input  logic [$clog2(SLV_NUM):0]   go_sel,
    input  logic                       go_rden,
    input  logic                       flush,
    input  logic                       clr,
    output logic                       busy,
    output logic [5:0]                 sts,
    output t_spi_if_ro                 spi_ifi_ro,
    input  t_spi_if_ri                 spi_ifi_ri
);

    t_ctl_state           state;
    t_ctl_state           state_nxt;
    logic                 strt;
    logic [SLV_SEL_W-1:0] slv_sel;
    logic                 rdata_en;
    logic                 fifo_flush;

    logic [34:0]          wd_head;
    logic                 wd_full, wd_empty, wd_ovf;
    logic [$clog2(WD_DEPTH):0] wd_cnt;
    logic [2:0]           ri_head;
    logic                 ri_full, ri_empty, ri_ovf;
    logic [$clog2(RI_DEPTH):0] ri_cnt;
    logic [31:0]          rd_head;
    logic                 rd_full, rd_empty, rd_ovf;
    logic [$clog2(RD_DEPTH):0] rd_cnt;
    logic [5:0]           sts_set;
    logic                 unused_fifo_state;

    assign fifo_flush = flush & ~busy;

    spi_sync_fifo #(.WIDTH(35), .DEPTH(WD_DEPTH)) u_wd_fifo (
        .clk(clk), .rst_n(rst_n), .flush(fifo_flush),
        .push(wd_push), .push_data({wd_data, wd_len, wd_lst}),
        .pop(spi_ifi_ri.wd_r), .head(wd_head),
        .full(wd_full), .empty(wd_empty), .count(wd_cnt), .ovf(wd_ovf)
    );

    spi_sync_fifo #(.WIDTH(3), .DEPTH(RI_DEPTH)) u_ri_fifo (
        .clk(clk), .rst_n(rst_n), .flush(fifo_flush),
        .push(ri_push), .push_data({ri_len, ri_lst}),
        .pop(spi_ifi_ri.rd_inf_r), .head(ri_head),
        .full(ri_full), .empty(ri_empty), .count(ri_cnt), .ovf(ri_ovf)
    );

    spi_sync_fifo #(.WIDTH(32), .DEPTH(RD_DEPTH)) u_rd_fifo (
        .clk(clk), .rst_n(rst_n), .flush(fifo_flush),
        .push(spi_ifi_ri.rd_ind), .push_data(spi_ifi_ri.rdata),
        .pop(rd_pop), .head(rd_head),
        .full(rd_full), .empty(rd_empty), .count(rd_cnt), .ovf(rd_ovf)
    );

    assign unused_fifo_state = ^{wd_full, ri_full, wd_cnt, ri_cnt, rd_cnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (go)              state_nxt = ST_RUN;
            ST_RUN:  if (spi_ifi_ri.done) state_nxt = ST_FIN;
            ST_FIN:                       state_nxt = ST_IDLE;
            default:                      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        strt = (state == ST_RUN);
        busy = (state != ST_IDLE);
    end

    // Selection is captured only on an accepted go, so a go during busy leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slv_sel  <= '0;
            rdata_en <= 1'b0;
        end else if (state == ST_IDLE && go) begin
            slv_sel  <= SLV_SEL_W'(go_sel);
            rdata_en <= go_rden;
        end
    end

    assign sts_set = {(state == ST_RUN) & spi_ifi_ri.done,
                      spi_ifi_ri.wdat_timeout,
                      spi_ifi_ri.rd_inf_timeout,
                      spi_ifi_ri.rdat_timeout,
                      wd_ovf | ri_ovf | rd_ovf,
                      rd_pop & rd_empty};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sts <= '0;
        else        sts <= sts_update(sts, sts_set, clr);
    end

    assign rd_data = rd_head;
    assign rd_vld  = ~rd_empty;

    assign spi_ifi_ro = '{
        rwdata:       wd_head[34:3],
        wd_len:       wd_head[2:1],
        wd_lst:       wd_head[0],
        wd_empty:     wd_empty,
        rd_len:       ri_head[2:1],
        rd_lst:       ri_head[0],
        rd_inf_empty: ri_empty,
        rd_rdy:       rd_full,
        strt:         strt,
        slv_sel:      slv_sel,
        rdata_en:     rdata_en
    };

endmodule

// File: tb/tb_spi_if_buf.sv
// Directed bench for spi_if_buf: vector tables for FIFO traffic, hand sequences for FSM/status corners.
module tb_spi_if_buf;
    import spi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wd_push, wd_lst, ri_push, ri_lst, rd_pop, rd_vld;
    logic [31:0] wd_data, rd_data;
    logic [1:0]  wd_len, ri_len;
    logic        go, go_rden, flush, clr, busy;
    logic [0:0]  go_sel;
    logic [5:0]  sts;
    t_spi_if_ro  ro;
    t_spi_if_ri  ri;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  len;
        logic        lst;
        logic [31:0] exp_head;
        logic [1:0]  exp_len;
        logic        exp_lst;
    } wvec_t;

    wvec_t wvec [3];

    spi_if_buf dut (
        .clk(clk), .rst_n(rst_n),
        .wd_push(wd_push), .wd_data(wd_data), .wd_len(wd_len), .wd_lst(wd_lst),
        .ri_push(ri_push), .ri_len(ri_len), .ri_lst(ri_lst),
        .rd_pop(rd_pop), .rd_data(rd_data), .rd_vld(rd_vld),
        .go(go), .go_sel(go_sel), .go_rden(go_rden),
        .flush(flush), .clr(clr), .busy(busy), .sts(sts),
        .spi_ifi_ro(ro), .spi_ifi_ri(ri)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_wd(input logic [31:0] d, input logic [1:0] l, input logic last);
        wd_push = 1'b1; wd_data = d; wd_len = l; wd_lst = last;
        tick();
        wd_push = 1'b0;
    endtask

    task automatic pulse_go(input logic sel, input logic rden);
        go = 1'b1; go_sel = sel; go_rden = rden;
        tick();
        go = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        wvec[0] = '{32'h0000_00A5, 2'd0, 1'b0, 32'h0000_00A5, 2'd0, 1'b0};
        wvec[1] = '{32'h0000_BEEF, 2'd1, 1'b0, 32'h0000_BEEF, 2'd1, 1'b0};
        wvec[2] = '{32'hDEAD_BEEF, 2'd3, 1'b1, 32'hDEAD_BEEF, 2'd3, 1'b1};

        rst_n = 1'b0; wd_push = 0; wd_data = 0; wd_len = 0; wd_lst = 0;
        ri_push = 0; ri_len = 0; ri_lst = 0; rd_pop = 0;
        go = 0; go_sel = 0; go_rden = 0; flush = 0; clr = 0;
        ri = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_sts", sts, 0);
        chk("rst_rd_vld", rd_vld, 0);
        chk("rst_strt", ro.strt, 0);
        chk("rst_slv_sel", ro.slv_sel, 0);
        chk("rst_rdata_en", ro.rdata_en, 0);
        chk("rst_wd_empty", ro.wd_empty, 1);
        chk("rst_ri_empty", ro.rd_inf_empty, 1);
        rst_n = 1'b1;
        tick();

        // Three words with lengths 0/1/3, drained by the controller during a transaction
        for (int i = 0; i < 3; i++) push_wd(wvec[i].data, wvec[i].len, wvec[i].lst);
        chk("wd_not_empty", ro.wd_empty, 0);
        pulse_go(1'b0, 1'b0);
        chk("go_strt", ro.strt, 1);
        chk("go_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wd_head%0d", i), ro.rwdata, wvec[i].exp_head);
            chk($sformatf("wd_len%0d", i), ro.wd_len, wvec[i].exp_len);
            chk($sformatf("wd_lst%0d", i), ro.wd_lst, wvec[i].exp_lst);
            ri.wd_r = 1'b1;
            tick();
            ri.wd_r = 1'b0;
        end
        chk("wd_empty_after3", ro.wd_empty, 1);
        ri.done = 1'b1;
        tick();
        ri.done = 1'b0;
        chk("done_strt", ro.strt, 0);
        chk("done_busy_fin", busy, 1);
        chk("done_sts", sts, 6'b100000);
        tick();
        chk("done_busy_idle", busy, 0);
        pulse_clr();
        chk("clr_sts", sts, 0);

        // Read-info FIFO show-ahead
        ri_push = 1'b1; ri_len = 2'd2; ri_lst = 1'b1;
        tick();
        ri_push = 1'b0;
        chk("ri_not_empty", ro.rd_inf_empty, 0);
        chk("ri_len", ro.rd_len, 2);
        chk("ri_lst", ro.rd_lst, 1);
        ri.rd_inf_r = 1'b1;
        tick();
        ri.rd_inf_r = 1'b0;
        chk("ri_empty", ro.rd_inf_empty, 1);

        // Nine pushes into an eight-deep write FIFO
        for (int i = 0; i < 9; i++) push_wd(32'h100 + i, 2'd3, 1'b0);
        chk("ovf_sts", sts, 6'b000010);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_head%0d", i), ro.rwdata, 32'h100 + i);
            ri.wd_r = 1'b1;
            tick();
            ri.wd_r = 1'b0;
        end
        chk("ovf_drained", ro.wd_empty, 1);
        pulse_clr();

        // Fill the read-data FIFO from the controller side
        for (int i = 0; i < 8; i++) begin
            ri.rd_ind = 1'b1; ri.rdata = 32'h1000 + i;
            tick();
        end
        ri.rd_ind = 1'b0;
        chk("rd_rdy_full", ro.rd_rdy, 1);
        chk("rd_vld_full", rd_vld, 1);
        chk("rd_data0", rd_data, 32'h1000);
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
        chk("rd_rdy_after_pop", ro.rd_rdy, 0);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("rd_data%0d", i), rd_data, 32'h1000 + i);
            rd_pop = 1'b1;
            tick();
            rd_pop = 1'b0;
        end
        chk("rd_vld_empty", rd_vld, 0);
        chk("rd_no_ovf", sts, 0);
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
        chk("udf_sts", sts, 6'b000001);
        pulse_clr();

        // Push and pop together on a one-entry FIFO
        ri.rd_ind = 1'b1; ri.rdata = 32'hAAAA;
        tick();
        ri.rdata = 32'hBBBB; rd_pop = 1'b1;
        tick();
        ri.rd_ind = 1'b0; rd_pop = 1'b0;
        chk("pp_head", rd_data, 32'hBBBB);
        chk("pp_vld", rd_vld, 1);
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
        chk("pp_empty", rd_vld, 0);
        chk("pp_sts", sts, 0);

        // Selection capture, ignored go, timeout, flush during busy
        push_wd(32'h55, 2'd0, 1'b1);
        pulse_go(1'b1, 1'b1);
        chk("sel_strt", ro.strt, 1);
        chk("sel_slv", ro.slv_sel, 1);
        chk("sel_rden", ro.rdata_en, 1);
        pulse_go(1'b0, 1'b0);
        chk("busy_go_slv", ro.slv_sel, 1);
        chk("busy_go_rden", ro.rdata_en, 1);
        ri.rdat_timeout = 1'b1;
        tick();
        ri.rdat_timeout = 1'b0;
        chk("rdat_to_sts", sts, 6'b000100);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy_wd", ro.wd_empty, 0);
        ri.done = 1'b1;
        tick();
        ri.done = 1'b0;
        chk("run_done_strt", ro.strt, 0);
        chk("run_done_sts", sts, 6'b100100);
        tick();
        chk("run_idle_busy", busy, 0);
        pulse_clr();
        chk("run_clr_sts", sts, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle_wd", ro.wd_empty, 1);

        // A set event coinciding with clr survives
        clr = 1'b1; ri.wdat_timeout = 1'b1;
        tick();
        clr = 1'b0; ri.wdat_timeout = 1'b0;
        chk("clr_vs_set", sts, 6'b010000);
        pulse_clr();

        // Reset in the middle of a transaction
        for (int i = 0; i < 4; i++) push_wd(32'h200 + i, 2'd3, i == 3);
        pulse_go(1'b1, 1'b0);
        ri.rd_inf_timeout = 1'b1;
        tick();
        ri.rd_inf_timeout = 1'b0;
        chk("pre_rst_sts", sts, 6'b001000);
        chk("pre_rst_strt", ro.strt, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_strt", ro.strt, 0);
        chk("mid_rst_wd_empty", ro.wd_empty, 1);
        chk("mid_rst_sts", sts, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_slv", ro.slv_sel, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
